// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the SPI master clock engine:
//   - spi_state_e  : frame FSM states (IDLE / RUN / TRAIL)
//   - spi_mode_t   : decoded CPOL/CPHA mode bits latched per frame
//   - calc_divisor : full SCLK period in PCLK cycles, (sppr+1)*2^(spr+1)
//   - calc_half    : SCLK half-period in PCLK cycles, (sppr+1)*2^spr
//   - decode_mode  : folds cpol/cphase into the fields the strobe decode uses
package spi_pkg;

  // Half-period reaches 8*128 = 1024, which needs 11 bits
  localparam int unsigned HALF_W     = 11;
  // Full period reaches 2048, which needs 12 bits
  localparam int unsigned BASE_DIV_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_TRAIL
  } spi_state_e;

  typedef struct packed {
    logic idle_level;      // SCLK level between frames
    logic sample_on_lead;  // 1: sample on odd edges, shift on even edges
  } spi_mode_t;

  function automatic logic [BASE_DIV_W-1:0] calc_divisor(input logic [2:0] sppr,
                                                         input logic [2:0] spr);
    logic [3:0] mult;
    mult = {1'b0, sppr} + 4'd1;
    return {8'd0, mult} << ({1'b0, spr} + 4'd1);
  endfunction

  function automatic logic [HALF_W-1:0] calc_half(input logic [2:0] sppr,
                                                  input logic [2:0] spr);
    logic [3:0] mult;
    mult = {1'b0, sppr} + 4'd1;
    return {7'd0, mult} << spr;
  endfunction

  function automatic spi_mode_t decode_mode(input logic cpol, input logic cphase);
    spi_mode_t m;
    m.idle_level     = cpol;
    m.sample_on_lead = ~cphase;
    return m;
  endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// spi_half_period_timer
// Loadable down-counter that paces SCLK half-periods. A load captures the
// reload value (H-1) and starts the count; each time the count reaches zero
// it reloads itself and raises tc_o for that cycle. hold_i freezes the count
// and suppresses tc_o so a stalled frame resumes exactly where it stopped.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : force the count to zero (highest priority)
//   load_i         : load load_val_i into count and reload register
//   load_val_i     : half-period minus one
//   run_i          : counting enabled (engine busy)
//   hold_i         : freeze counting
//   tc_o           : terminal-count pulse, one cycle per half-period
module spi_half_period_timer
  import spi_pkg::*;
#(
  parameter int unsigned CNT_W = HALF_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             run_i,
  input  logic             hold_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload_q, reload_d;

  // Clear beats load beats counting; wrap reloads from the latched period
  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d    = load_val_i;
      reload_d = load_val_i;
    end else if (run_i && !hold_i) begin
      if (cnt_q == '0) begin
        cnt_d = reload_q;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

  assign tc_o = run_i && !hold_i && (cnt_q == '0);

endmodule

// File: rtl/spi_sclk_engine.sv
// spi_sclk_engine
// SPI master clock engine. Derives SCLK from PCLK using the SPPR/SPR divisor
// and runs one frame of N bits per accepted start, emitting single-cycle
// sample/shift strobes for all CPOL/CPHA modes plus busy and frame_done.
// Ports:
//   PCLK, PRESETn          : clock, asynchronous active-low reset
//   enable                 : low aborts any frame and parks SCLK at cpol
//   start                  : one-cycle frame request (ignored while busy)
//   stall                  : freezes SCLK, counters and strobes mid-frame
//   cpol, cphase           : SPI mode, latched at frame start
//   sppr, spr              : rate selects, latched at frame start
//   frame_len              : bits per frame, 0 meaning 2^FRAME_W
//   baud_divisor           : live (sppr+1)*2^(spr+1)
//   sclk                   : registered serial clock
//   busy                   : frame in progress (RUN or TRAIL)
//   sample_stb, shift_stb  : datapath strobes, aligned with the SCLK edge
//   frame_done             : pulse in the last cycle of a completed frame
module spi_sclk_engine
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W   = 12,
  parameter int unsigned FRAME_W = 5
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               enable,
  input  logic               start,
  input  logic               stall,
  input  logic               cpol,
  input  logic               cphase,
  input  logic [2:0]         sppr,
  input  logic [2:0]         spr,
  input  logic [FRAME_W-1:0] frame_len,
  output logic [DIV_W-1:0]   baud_divisor,
  output logic               sclk,
  output logic               busy,
  output logic               sample_stb,
  output logic               shift_stb,
  output logic               frame_done
);

  // Edge numbers run to 2N = 2^(FRAME_W+1)
  localparam int unsigned EDGE_W = FRAME_W + 2;

  spi_state_e          state_q, state_d;
  logic [EDGE_W-1:0]   edge_q, edge_d, edge_next, last_edge;
  logic [FRAME_W:0]    n_q, n_d, n_live;
  spi_mode_t           mode_q, mode_d;
  logic                sclk_q, sclk_d;
  logic                sample_q, sample_d;
  logic                shift_q, shift_d;
  logic                tmr_clear, tmr_load, tmr_tc;
  logic [HALF_W-1:0]   half_m1;

  assign baud_divisor = DIV_W'(calc_divisor(sppr, spr));
  assign half_m1      = calc_half(sppr, spr) - HALF_W'(1);
  assign n_live       = (frame_len == '0) ? {1'b1, {FRAME_W{1'b0}}} : {1'b0, frame_len};
  assign last_edge    = {n_q, 1'b0};
  assign edge_next    = edge_q + EDGE_W'(1);

  spi_half_period_timer #(
    .CNT_W(HALF_W)
  ) u_half_timer (
    .clk_i      (PCLK),
    .rst_ni     (PRESETn),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .load_val_i (half_m1),
    .run_i      (busy),
    .hold_i     (stall),
    .tc_o       (tmr_tc)
  );

  // Frame FSM, edge counter and strobe decode. Strobes are registered on the
  // same edge that toggles sclk so the datapath sees them together. A strobe
  // pending when stall rises is kept in its register and masked at the output
  // until the stall ends, so no bit is lost.
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    sclk_d    = sclk_q;
    sample_d  = 1'b0;
    shift_d   = 1'b0;
    mode_d    = mode_q;
    n_d       = n_q;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;

    if (!enable) begin
      state_d   = ST_IDLE;
      edge_d    = '0;
      sclk_d    = cpol;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sclk_d = cpol;
          edge_d = '0;
          if (start) begin
            state_d  = ST_RUN;
            mode_d   = decode_mode(cpol, cphase);
            n_d      = n_live;
            tmr_load = 1'b1;
            // With cphase=0 the first MOSI bit must be on the wire before
            // the first (sampling) edge
            shift_d  = ~cphase;
          end else begin
            tmr_clear = 1'b1;
          end
        end

        ST_RUN: begin
          if (stall) begin
            sample_d = sample_q;
            shift_d  = shift_q;
          end else if (tmr_tc) begin
            edge_d = edge_next;
            sclk_d = ~sclk_q;
            // Odd edges are leading, even edges trailing
            if (edge_next[0]) begin
              sample_d = mode_q.sample_on_lead;
              shift_d  = ~mode_q.sample_on_lead;
            end else begin
              sample_d = ~mode_q.sample_on_lead;
              // The final trailing edge has no further bit to drive
              shift_d  = mode_q.sample_on_lead && (edge_next != last_edge);
            end
            if (edge_next == last_edge) begin
              state_d = ST_TRAIL;
            end
          end
        end

        ST_TRAIL: begin
          if (stall) begin
            sample_d = sample_q;
            shift_d  = shift_q;
          end else if (tmr_tc) begin
            state_d   = ST_IDLE;
            edge_d    = '0;
            sclk_d    = mode_q.idle_level;
            tmr_clear = 1'b1;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          edge_d    = '0;
          tmr_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= ST_IDLE;
      edge_q   <= '0;
      n_q      <= '0;
      mode_q   <= '0;
      sclk_q   <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      sclk_q   <= sclk_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
    end
  end

  assign sclk       = sclk_q;
  assign busy       = (state_q != ST_IDLE);
  assign sample_stb = sample_q & ~stall;
  assign shift_stb  = shift_q & ~stall;
  assign frame_done = enable && (state_q == ST_TRAIL) && tmr_tc;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// tb_spi_sclk_engine
// Directed bench for spi_sclk_engine. A negedge monitor tallies toggles,
// strobes, busy cycles and frame_done pulses; each test task drives one
// scenario and compares the tallies against hand-computed frame figures.
module tb_spi_sclk_engine;

  logic        PCLK;
  logic        PRESETn;
  logic        enable;
  logic        start;
  logic        stall;
  logic        cpol;
  logic        cphase;
  logic [2:0]  sppr;
  logic [2:0]  spr;
  logic [4:0]  frame_len;
  logic [11:0] baud_divisor;
  logic        sclk;
  logic        busy;
  logic        sample_stb;
  logic        shift_stb;
  logic        frame_done;

  int vecCount = 0;
  int errCount = 0;

  int   toggleCnt, sampleCnt, shiftCnt, busyCnt, doneCnt;
  int   shiftLowCnt, sampleHighCnt, cycIdx, firstBusyCyc, firstToggleCyc;
  logic prevSclk;

  spi_sclk_engine #(
    .DIV_W  (12),
    .FRAME_W(5)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .enable      (enable),
    .start       (start),
    .stall       (stall),
    .cpol        (cpol),
    .cphase      (cphase),
    .sppr        (sppr),
    .spr         (spr),
    .frame_len   (frame_len),
    .baud_divisor(baud_divisor),
    .sclk        (sclk),
    .busy        (busy),
    .sample_stb  (sample_stb),
    .shift_stb   (shift_stb),
    .frame_done  (frame_done)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Tally activity mid-cycle, away from the rising edge
  always @(negedge PCLK) begin
    if (PRESETn) begin
      cycIdx++;
      if (busy) begin
        busyCnt++;
        if (firstBusyCyc < 0) firstBusyCyc = cycIdx;
      end
      if (sclk !== prevSclk) begin
        toggleCnt++;
        if (firstToggleCyc < 0) firstToggleCyc = cycIdx;
      end
      prevSclk = sclk;
      if (sample_stb) begin
        sampleCnt++;
        if (sclk) sampleHighCnt++;
      end
      if (shift_stb) begin
        shiftCnt++;
        if (!sclk) shiftLowCnt++;
      end
      if (frame_done) doneCnt++;
    end
  end

  task automatic clearCounters();
    toggleCnt = 0; sampleCnt = 0; shiftCnt = 0; busyCnt = 0; doneCnt = 0;
    shiftLowCnt = 0; sampleHighCnt = 0; cycIdx = 0;
    firstBusyCyc = -1; firstToggleCyc = -1;
    prevSclk = sclk;
  endtask

  task automatic setConfig(input logic pol, input logic pha, input logic [2:0] pr,
                           input logic [2:0] r, input logic [4:0] len);
    cpol = pol; cphase = pha; sppr = pr; spr = r; frame_len = len;
    repeat (2) begin @(posedge PCLK); #1; end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge PCLK); #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(posedge PCLK); #1;
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; enable = 1'b1; start = 1'b0; stall = 1'b0;
    cpol = 1'b1; cphase = 1'b0; sppr = 3'd0; spr = 3'd0; frame_len = 5'd8;
    repeat (3) @(posedge PCLK);
    #1;
    vecCount++; if (sclk !== 1'b0) begin errCount++; $display("[TB] FAIL reset_sclk: got %b expected 0", sclk); end
    vecCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vecCount++; if ({sample_stb, shift_stb, frame_done} !== 3'b000) begin errCount++; $display("[TB] FAIL reset_strobes: got %b expected 000", {sample_stb, shift_stb, frame_done}); end
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    vecCount++; if (sclk !== 1'b1) begin errCount++; $display("[TB] FAIL reset_cpol_load: got %b expected 1", sclk); end
  endtask

  task automatic test_divisor();
    sppr = 3'd0; spr = 3'd0; #1;
    vecCount++; if (baud_divisor !== 12'd2) begin errCount++; $display("[TB] FAIL div_min: got %0d expected 2", baud_divisor); end
    sppr = 3'd2; spr = 3'd3; #1;
    vecCount++; if (baud_divisor !== 12'd48) begin errCount++; $display("[TB] FAIL div_mid: got %0d expected 48", baud_divisor); end
    sppr = 3'd7; spr = 3'd7; #1;
    vecCount++; if (baud_divisor !== 12'd2048) begin errCount++; $display("[TB] FAIL div_max: got %0d expected 2048", baud_divisor); end
  endtask

  task automatic test_fastest_mode0();
    bit ok;
    setConfig(1'b0, 1'b0, 3'd0, 3'd0, 5'd8);
    clearCounters();
    pulseStart();
    waitIdle(100, ok);
    vecCount++; if (!ok) begin errCount++; $display("[TB] FAIL m0_timeout: got busy %b expected 0", busy); end
    vecCount++; if (toggleCnt !== 16) begin errCount++; $display("[TB] FAIL m0_toggles: got %0d expected 16", toggleCnt); end
    vecCount++; if (sampleCnt !== 8) begin errCount++; $display("[TB] FAIL m0_samples: got %0d expected 8", sampleCnt); end
    vecCount++; if (shiftCnt !== 8) begin errCount++; $display("[TB] FAIL m0_shifts: got %0d expected 8", shiftCnt); end
    vecCount++; if (busyCnt !== 17) begin errCount++; $display("[TB] FAIL m0_busy: got %0d expected 17", busyCnt); end
    vecCount++; if (doneCnt !== 1) begin errCount++; $display("[TB] FAIL m0_done: got %0d expected 1", doneCnt); end
    vecCount++; if (sclk !== 1'b0) begin errCount++; $display("[TB] FAIL m0_sclk_end: got %b expected 0", sclk); end
    vecCount++; if (firstToggleCyc - firstBusyCyc !== 1) begin errCount++; $display("[TB] FAIL m0_latency: got %0d expected 1", firstToggleCyc - firstBusyCyc); end
  endtask

  task automatic test_mode3_slow();
    bit ok;
    setConfig(1'b1, 1'b1, 3'd1, 3'd1, 5'd4);
    clearCounters();
    pulseStart();
    waitIdle(200, ok);
    vecCount++; if (!ok) begin errCount++; $display("[TB] FAIL m3_timeout: got busy %b expected 0", busy); end
    vecCount++; if (firstToggleCyc - firstBusyCyc !== 4) begin errCount++; $display("[TB] FAIL m3_latency: got %0d expected 4", firstToggleCyc - firstBusyCyc); end
    vecCount++; if (busyCnt !== 36) begin errCount++; $display("[TB] FAIL m3_busy: got %0d expected 36", busyCnt); end
    vecCount++; if (toggleCnt !== 8) begin errCount++; $display("[TB] FAIL m3_toggles: got %0d expected 8", toggleCnt); end
    vecCount++; if (shiftLowCnt !== 4 || shiftCnt !== 4) begin errCount++; $display("[TB] FAIL m3_shift_falling: got %0d of %0d expected 4 of 4", shiftLowCnt, shiftCnt); end
    vecCount++; if (sampleHighCnt !== 4 || sampleCnt !== 4) begin errCount++; $display("[TB] FAIL m3_sample_rising: got %0d of %0d expected 4 of 4", sampleHighCnt, sampleCnt); end
    vecCount++; if (sclk !== 1'b1) begin errCount++; $display("[TB] FAIL m3_sclk_end: got %b expected 1", sclk); end
  endtask

  task automatic test_stall();
    bit   ok;
    logic frozen;
    int   frozenBad = 0;
    int   strobeBad = 0;
    setConfig(1'b0, 1'b0, 3'd1, 3'd0, 5'd4);
    clearCounters();
    pulseStart();
    repeat (4) begin @(posedge PCLK); #1; end
    stall  = 1'b1;
    frozen = sclk;
    repeat (10) begin
      @(negedge PCLK);
      if (sclk !== frozen) frozenBad++;
      if (sample_stb || shift_stb) strobeBad++;
      @(posedge PCLK); #1;
    end
    stall = 1'b0;
    waitIdle(100, ok);
    vecCount++; if (!ok) begin errCount++; $display("[TB] FAIL stall_timeout: got busy %b expected 0", busy); end
    vecCount++; if (frozenBad !== 0) begin errCount++; $display("[TB] FAIL stall_sclk_frozen: got %0d changes expected 0", frozenBad); end
    vecCount++; if (strobeBad !== 0) begin errCount++; $display("[TB] FAIL stall_strobes_low: got %0d strobes expected 0", strobeBad); end
    vecCount++; if (busyCnt !== 28) begin errCount++; $display("[TB] FAIL stall_busy: got %0d expected 28", busyCnt); end
    vecCount++; if (sampleCnt !== 4 || shiftCnt !== 4) begin errCount++; $display("[TB] FAIL stall_counts: got %0d/%0d expected 4/4", sampleCnt, shiftCnt); end
    vecCount++; if (toggleCnt !== 8 || doneCnt !== 1) begin errCount++; $display("[TB] FAIL stall_frame: got %0d toggles %0d done expected 8 and 1", toggleCnt, doneCnt); end
  endtask

  task automatic test_abort();
    bit ok;
    setConfig(1'b1, 1'b0, 3'd3, 3'd0, 5'd8);
    clearCounters();
    pulseStart();
    for (int n = 0; n < 200 && toggleCnt < 5; n++) begin @(posedge PCLK); #1; end
    vecCount++; if (toggleCnt !== 5) begin errCount++; $display("[TB] FAIL abort_edge5: got %0d expected 5", toggleCnt); end
    enable = 1'b0;
    @(posedge PCLK); #1;
    vecCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL abort_idle: got %b expected 0", busy); end
    vecCount++; if (sclk !== 1'b1) begin errCount++; $display("[TB] FAIL abort_sclk: got %b expected 1", sclk); end
    repeat (3) begin @(posedge PCLK); #1; end
    enable = 1'b1;
    vecCount++; if (doneCnt !== 0) begin errCount++; $display("[TB] FAIL abort_no_done: got %0d expected 0", doneCnt); end
    setConfig(1'b1, 1'b0, 3'd0, 3'd0, 5'd2);
    clearCounters();
    pulseStart();
    waitIdle(100, ok);
    vecCount++; if (!ok || busyCnt !== 5) begin errCount++; $display("[TB] FAIL abort_restart_busy: got %0d expected 5", busyCnt); end
    vecCount++; if (doneCnt !== 1) begin errCount++; $display("[TB] FAIL abort_restart_done: got %0d expected 1", doneCnt); end
  endtask

  task automatic test_frame_len_zero();
    bit ok;
    setConfig(1'b0, 1'b0, 3'd0, 3'd0, 5'd0);
    clearCounters();
    pulseStart();
    waitIdle(300, ok);
    vecCount++; if (!ok) begin errCount++; $display("[TB] FAIL len0_timeout: got busy %b expected 0", busy); end
    vecCount++; if (toggleCnt !== 64) begin errCount++; $display("[TB] FAIL len0_edges: got %0d expected 64", toggleCnt); end
    vecCount++; if (sampleCnt !== 32 || shiftCnt !== 32) begin errCount++; $display("[TB] FAIL len0_bits: got %0d/%0d expected 32/32", sampleCnt, shiftCnt); end
    vecCount++; if (busyCnt !== 65) begin errCount++; $display("[TB] FAIL len0_busy: got %0d expected 65", busyCnt); end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    setConfig(1'b0, 1'b1, 3'd0, 3'd0, 5'd4);
    clearCounters();
    pulseStart();
    @(posedge PCLK); #1;
    start = 1'b1;
    repeat (3) begin @(posedge PCLK); #1; end
    start = 1'b0;
    waitIdle(100, ok);
    vecCount++; if (!ok || busyCnt !== 9) begin errCount++; $display("[TB] FAIL busy_start_busy: got %0d expected 9", busyCnt); end
    vecCount++; if (doneCnt !== 1) begin errCount++; $display("[TB] FAIL busy_start_done: got %0d expected 1", doneCnt); end
    vecCount++; if (sampleCnt !== 4 || shiftCnt !== 4) begin errCount++; $display("[TB] FAIL busy_start_strobes: got %0d/%0d expected 4/4", sampleCnt, shiftCnt); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    setConfig(1'b0, 1'b0, 3'd0, 3'd0, 5'd2);
    clearCounters();
    pulseStart();
    for (int n = 0; n < 100 && frame_done !== 1'b1; n++) begin @(posedge PCLK); #1; end
    vecCount++; if (frame_done !== 1'b1) begin errCount++; $display("[TB] FAIL b2b_first_done: got %b expected 1", frame_done); end
    @(posedge PCLK); #1;
    vecCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL b2b_gap: got %b expected 0", busy); end
    pulseStart();
    vecCount++; if (busy !== 1'b1) begin errCount++; $display("[TB] FAIL b2b_accept: got %b expected 1", busy); end
    waitIdle(100, ok);
    vecCount++; if (!ok || busyCnt !== 10) begin errCount++; $display("[TB] FAIL b2b_busy: got %0d expected 10", busyCnt); end
    vecCount++; if (doneCnt !== 2) begin errCount++; $display("[TB] FAIL b2b_done: got %0d expected 2", doneCnt); end
  endtask

  task automatic test_reset_mid_frame();
    setConfig(1'b1, 1'b1, 3'd1, 3'd1, 5'd4);
    clearCounters();
    pulseStart();
    repeat (6) begin @(posedge PCLK); #1; end
    #2;
    PRESETn = 1'b0;
    #1;
    vecCount++; if (sclk !== 1'b0) begin errCount++; $display("[TB] FAIL arst_sclk: got %b expected 0", sclk); end
    vecCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL arst_busy: got %b expected 0", busy); end
    vecCount++; if ({sample_stb, shift_stb, frame_done} !== 3'b000) begin errCount++; $display("[TB] FAIL arst_strobes: got %b expected 000", {sample_stb, shift_stb, frame_done}); end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    vecCount++; if (sclk !== 1'b1 || busy !== 1'b0) begin errCount++; $display("[TB] FAIL arst_recover: got sclk %b busy %b expected 1 0", sclk, busy); end
  endtask

  initial begin
    test_reset();
    test_divisor();
    test_fastest_mode0();
    test_mode3_slow();
    test_stall();
    test_abort();
    test_frame_len_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
